wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Arbitrates the single register-file write port between the in-order pipeline's write-back stage and a long-latency unit (mul/div) that completes out of band. WB writes always win and pass through with zero latency, so forwarding timing is unchanged. Long-latency results are buffered in a small FIFO and written in idle WB slots. If they are starved for too long, the block requests a pipeline stall to force a free slot. The block sits between the WB stage output and the register file write port.

## Interface
- DEPTH, 2: long-latency result FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 4: consecutive denied cycles before a stall is requested (1..15)
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- wb_reg_write_in  in  1  WB stage write enable
- wb_rd_in  in  5  WB destination register
- wb_data_in  in  32  WB write data (already muxed ALU/memory)
- lu_valid  in  1  long-latency result valid
- lu_rd  in  5  long-latency destination register
- lu_data  in  32  long-latency result
- lu_ready  out  1  FIFO can accept this cycle
- rf_write_out  out  1  register file write enable
- rf_rd_out  out  5  register file write address; also drives forwarding
- rf_data_out  out  32  register file write data
- stall_req  out  1  request for the pipeline to bubble WB
- lu_pending  out  1  FIFO non-empty
- lu_pend_rd  out  5  rd of FIFO head; 0 when empty

## Operation
- WB active = wb_reg_write_in && wb_rd_in != 0. A WB write to x0 is treated as idle.
- Port mux (combinational):
  - WB active: rf_* = WB inputs.
  - Else, FIFO non-empty: rf_* = FIFO head and head is popped (grant).
  - Else: rf_write_out=0, rf_rd_out=0, rf_data_out=0.
- Accept: lu_valid && lu_ready. If lu_rd == 0, the result is accepted and discarded, not enqueued.
- lu_ready = !reset && count < DEPTH, computed from the registered count. There is no pass-through when full, even if a pop occurs in the same cycle.
- Simultaneous push and pop: count is unchanged. An empty FIFO cannot be written to the port in the same cycle it is pushed.
- FSM, starve_cnt 4 bits:
  - IDLE: FIFO empty. Transitions to PENDING on push.
  - PENDING: head not granted → starve_cnt++. When starve_cnt reaches STARVE_LIMIT → STARVED. Grant with FIFO still non-empty → starve_cnt=0, stay PENDING. Grant that empties the FIFO → IDLE.
  - STARVED: stall_req=1 (Moore). On grant → starve_cnt=0, then IDLE or PENDING by the post-pop occupancy.
- Pipeline contract: while stall_req=1, WB is idle from the following cycle. The grant therefore occurs within 1 cycle of stall_req rising.
- Pointers wrap modulo DEPTH. count has width log2(DEPTH)+1.

## Timing
- Reset values: FIFO empty, count=0, starve_cnt=0, state IDLE, stall_req=0, lu_pending=0, lu_pend_rd=0, lu_ready=0 while reset is high. rf_* follow the WB inputs combinationally, even during reset.
- Reset mid-operation discards all buffered results; no write of buffered data occurs afterward.
- WB path latency: 0 cycles, combinational.
- Long-latency path latency: accept at edge N; earliest port write in cycle N+1.
- Worst-case wait after stall_req rises: 1 cycle.
- stall_req deasserts the cycle after the grant edge.

## Structure
- Shared package wb_pkg:
  - XLEN=32, REG_ADDR_W=5.
  - Enum arb_state_t {IDLE, PENDING, STARVED}.
- Sub-module wb_lu_fifo: parameterized synchronous FIFO exposing push, pop, head_rd, head_data, count, full, empty.
- Arbiter mux and FSM live in the top module.

## Test plan
- Reset, then WB writes x5=0x1234 with lu_valid=0 → rf_write_out=1, rf_rd_out=5, rf_data_out=0x1234 in the same cycle. lu_ready=1 after reset drops.
- WB idle, lu_valid with rd=7, data=0xCAFE accepted at edge N → cycle N+1 shows rf_rd_out=7, rf_data_out=0xCAFE. FIFO returns to empty and state to IDLE.
- WB active every cycle, one result pushed → stall_req=1 after exactly 4 denied cycles (STARVE_LIMIT=4). When the bench drops WB the next cycle, the result is written and stall_req clears the following cycle.
- Three back-to-back lu_valid with WB active → first two accepted, lu_ready=0 on the third. After 2 idle WB cycles, results are written in push order.
- lu_valid with rd=0 and WB write to x0 in the same cycle → lu accepted, nothing enqueued, rf_write_out=0, lu_pending=0.
- FIFO holds 2 entries, reset asserted for 1 cycle → lu_pending=0, stall_req=0, and no buffered data ever appears on rf_*.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, arbiter state encoding and buffered-result entry type.
package wb_pkg;
   localparam int XLEN = 32;
   localparam int REG_ADDR_W = 5;
   typedef enum logic [1:0] {IDLE, PENDING, STARVED} arb_state_t;
   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0] data;
   } lu_entry_t;
endpackage

// File: rtl/wb_lu_fifo.sv
// wb_lu_fifo: small synchronous FIFO holding long-latency results until a free write-port slot.
module wb_lu_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic push,
   input  logic pop,
   input  logic [REG_ADDR_W-1:0] push_rd,
   input  logic [XLEN-1:0] push_data,
   output logic [REG_ADDR_W-1:0] head_rd,
   output logic [XLEN-1:0] head_data,
   output logic [$clog2(DEPTH):0] count,
   output logic full,
   output logic empty
);
   localparam int AW = $clog2(DEPTH);
   lu_entry_t mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   assign head_rd = mem[rd_ptr].rd;
   assign head_data = mem[rd_ptr].data;
   assign full = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= '{rd: push_rd, data: push_data};
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between WB (always wins, zero latency)
// and buffered long-latency results, requesting a stall when those are starved too long.
module wb_port_arbiter
   import wb_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic wb_reg_write_in,
   input  logic [REG_ADDR_W-1:0] wb_rd_in,
   input  logic [XLEN-1:0] wb_data_in,
   input  logic lu_valid,
   input  logic [REG_ADDR_W-1:0] lu_rd,
   input  logic [XLEN-1:0] lu_data,
   output logic lu_ready,
   output logic rf_write_out,
   output logic [REG_ADDR_W-1:0] rf_rd_out,
   output logic [XLEN-1:0] rf_data_out,
   output logic stall_req,
   output logic lu_pending,
   output logic [REG_ADDR_W-1:0] lu_pend_rd
);
   localparam int AW = $clog2(DEPTH);
   logic wb_active, grant, push, full, empty;
   logic [AW:0] count;
   logic [REG_ADDR_W-1:0] head_rd;
   logic [XLEN-1:0] head_data;
   arb_state_t state;
   logic [3:0] starve_cnt;
   wb_lu_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock(clock),
      .reset(reset),
      .push(push),
      .pop(grant),
      .push_rd(lu_rd),
      .push_data(lu_data),
      .head_rd(head_rd),
      .head_data(head_data),
      .count(count),
      .full(full),
      .empty(empty)
   );
   assign wb_active = wb_reg_write_in && wb_rd_in != '0;
   // Grant is blocked during reset so buffered data being discarded never reaches the port.
   assign grant = !reset && !wb_active && !empty;
   assign lu_ready = !reset && !full;
   assign push = lu_valid && lu_ready && lu_rd != '0;
   assign rf_write_out = wb_active || grant;
   assign rf_rd_out = wb_active ? wb_rd_in : grant ? head_rd : '0;
   assign rf_data_out = wb_active ? wb_data_in : grant ? head_data : '0;
   assign lu_pending = !empty;
   assign lu_pend_rd = empty ? '0 : head_rd;
   assign stall_req = state == STARVED;
   // A grant pops one entry; the FIFO stays non-empty if it held more or is refilled this edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         starve_cnt <= '0;
      end else begin
         case (state)
            IDLE: if (push) state <= PENDING;
            PENDING, STARVED:
               if (grant) begin
                  starve_cnt <= '0;
                  state <= (count > (AW+1)'(1) || push) ? PENDING : IDLE;
               end else if (state == PENDING) begin
                  starve_cnt <= starve_cnt + 4'd1;
                  if (starve_cnt + 4'd1 == 4'(STARVE_LIMIT)) state <= STARVED;
               end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed scenario tasks with hand-computed expectations.
module tb_wb_port_arbiter;
   logic clock = 0, reset;
   logic wb_reg_write_in, lu_valid;
   logic [4:0] wb_rd_in, lu_rd;
   logic [31:0] wb_data_in, lu_data;
   logic lu_ready, rf_write_out, stall_req, lu_pending;
   logic [4:0] rf_rd_out, lu_pend_rd;
   logic [31:0] rf_data_out;
   int total = 0, passed = 0;

   wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
      .clock(clock), .reset(reset),
      .wb_reg_write_in(wb_reg_write_in), .wb_rd_in(wb_rd_in), .wb_data_in(wb_data_in),
      .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
      .rf_write_out(rf_write_out), .rf_rd_out(rf_rd_out), .rf_data_out(rf_data_out),
      .stall_req(stall_req), .lu_pending(lu_pending), .lu_pend_rd(lu_pend_rd)
   );

   always #5 clock = ~clock;

   task automatic drive(input logic rst, input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
      @(posedge clock);
      #1;
      reset = rst; wb_reg_write_in = we; wb_rd_in = wrd; wb_data_in = wd;
      lu_valid = lv; lu_rd = lrd; lu_data = ld;
      @(negedge clock);
   endtask

   task automatic test_reset;
      drive(1, 1, 5'd3, 32'hAA, 1, 5'd4, 32'h44);
      drive(1, 1, 5'd3, 32'hAA, 1, 5'd4, 32'h44);
      total++;
      if ({lu_ready, stall_req, lu_pending, lu_pend_rd} !== 8'h00)
         $display("FAIL reset_status: got %b want 00000000", {lu_ready, stall_req, lu_pending, lu_pend_rd});
      else passed++;
      total++;
      if ({rf_write_out, rf_rd_out, rf_data_out} !== {1'b1, 5'd3, 32'hAA})
         $display("FAIL reset_wb_follow: got %b/%0d/%h want 1/3/aa", rf_write_out, rf_rd_out, rf_data_out);
      else passed++;
   endtask

   task automatic test_wb_pass;
      drive(0, 1, 5'd5, 32'h1234, 0, 5'd0, 32'h0);
      total++;
      if ({rf_write_out, rf_rd_out, rf_data_out} !== {1'b1, 5'd5, 32'h1234})
         $display("FAIL wb_pass: got %b/%0d/%h want 1/5/1234", rf_write_out, rf_rd_out, rf_data_out);
      else passed++;
      total++;
      if (lu_ready !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", lu_ready);
      else passed++;
   endtask

   task automatic test_lu_path;
      drive(0, 0, 5'd0, 32'h0, 1, 5'd7, 32'hCAFE);
      total++;
      if ({lu_ready, rf_write_out} !== 2'b10)
         $display("FAIL lu_accept_cycle: got ready=%b write=%b want ready=1 write=0", lu_ready, rf_write_out);
      else passed++;
      drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      total++;
      if ({rf_write_out, rf_rd_out, rf_data_out} !== {1'b1, 5'd7, 32'hCAFE})
         $display("FAIL lu_write: got %b/%0d/%h want 1/7/cafe", rf_write_out, rf_rd_out, rf_data_out);
      else passed++;
      total++;
      if ({lu_pending, lu_pend_rd} !== {1'b1, 5'd7})
         $display("FAIL lu_pend_head: got %b/%0d want 1/7", lu_pending, lu_pend_rd);
      else passed++;
      drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      total++;
      if ({lu_pending, rf_write_out, stall_req, dut.state} !== {3'b000, wb_pkg::IDLE})
         $display("FAIL lu_drained: got pend=%b write=%b stall=%b state=%0d want 0/0/0/IDLE", lu_pending, rf_write_out, stall_req, dut.state);
      else passed++;
   endtask

   task automatic test_starve;
      drive(0, 1, 5'd1, 32'h1, 1, 5'd9, 32'h99);
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 5'd1, 32'h1, 0, 5'd0, 32'h0);
         total++;
         if ({stall_req, rf_rd_out} !== {1'b0, 5'd1})
            $display("FAIL starve_denied%0d: got stall=%b rd=%0d want 0/1", i, stall_req, rf_rd_out);
         else passed++;
      end
      drive(0, 1, 5'd1, 32'h1, 0, 5'd0, 32'h0);
      total++;
      if (stall_req !== 1'b1) $display("FAIL starve_stall: got %b want 1", stall_req);
      else passed++;
      drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      total++;
      if ({stall_req, rf_write_out, rf_rd_out, rf_data_out} !== {2'b11, 5'd9, 32'h99})
         $display("FAIL starve_grant: got %b/%b/%0d/%h want 1/1/9/99", stall_req, rf_write_out, rf_rd_out, rf_data_out);
      else passed++;
      drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      total++;
      if ({stall_req, lu_pending, rf_write_out} !== 3'b000)
         $display("FAIL starve_clear: got %b want 000", {stall_req, lu_pending, rf_write_out});
      else passed++;
   endtask

   task automatic test_back_to_back;
      drive(0, 1, 5'd2, 32'h2, 1, 5'd10, 32'hA0);
      total++;
      if (lu_ready !== 1'b1) $display("FAIL b2b_ready1: got %b want 1", lu_ready);
      else passed++;
      drive(0, 1, 5'd2, 32'h2, 1, 5'd11, 32'hB0);
      total++;
      if (lu_ready !== 1'b1) $display("FAIL b2b_ready2: got %b want 1", lu_ready);
      else passed++;
      drive(0, 1, 5'd2, 32'h2, 1, 5'd12, 32'hC0);
      total++;
      if ({lu_ready, lu_pend_rd} !== {1'b0, 5'd10})
         $display("FAIL b2b_full: got ready=%b head=%0d want 0/10", lu_ready, lu_pend_rd);
      else passed++;
      drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      total++;
      if ({rf_write_out, rf_rd_out, rf_data_out} !== {1'b1, 5'd10, 32'hA0})
         $display("FAIL b2b_first: got %b/%0d/%h want 1/10/a0", rf_write_out, rf_rd_out, rf_data_out);
      else passed++;
      drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      total++;
      if ({rf_write_out, rf_rd_out, rf_data_out} !== {1'b1, 5'd11, 32'hB0})
         $display("FAIL b2b_second: got %b/%0d/%h want 1/11/b0", rf_write_out, rf_rd_out, rf_data_out);
      else passed++;
      drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      total++;
      if ({rf_write_out, lu_pending, stall_req} !== 3'b000)
         $display("FAIL b2b_done: got %b want 000", {rf_write_out, lu_pending, stall_req});
      else passed++;
   endtask

   task automatic test_x0;
      drive(0, 1, 5'd0, 32'h55, 1, 5'd0, 32'h77);
      total++;
      if ({lu_ready, rf_write_out, rf_rd_out, rf_data_out} !== {2'b10, 5'd0, 32'h0})
         $display("FAIL x0_cycle: got %b/%b/%0d/%h want 1/0/0/0", lu_ready, rf_write_out, rf_rd_out, rf_data_out);
      else passed++;
      drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      total++;
      if ({lu_pending, rf_write_out} !== 2'b00)
         $display("FAIL x0_discard: got pend=%b write=%b want 0/0", lu_pending, rf_write_out);
      else passed++;
   endtask

   task automatic test_reset_mid;
      drive(0, 1, 5'd3, 32'h3, 1, 5'd20, 32'h200);
      drive(0, 1, 5'd3, 32'h3, 1, 5'd21, 32'h210);
      drive(0, 1, 5'd3, 32'h3, 0, 5'd0, 32'h0);
      total++;
      if ({lu_pending, lu_ready} !== 2'b10)
         $display("FAIL mid_full: got pend=%b ready=%b want 1/0", lu_pending, lu_ready);
      else passed++;
      drive(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      total++;
      if (rf_write_out !== 1'b0) $display("FAIL mid_reset_write: got %b want 0", rf_write_out);
      else passed++;
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
         total++;
         if ({lu_pending, stall_req, rf_write_out, rf_data_out} !== {3'b000, 32'h0})
            $display("FAIL mid_after%0d: got pend=%b stall=%b write=%b data=%h want 0/0/0/0", i, lu_pending, stall_req, rf_write_out, rf_data_out);
         else passed++;
      end
   endtask

   initial begin
      reset = 1; wb_reg_write_in = 0; wb_rd_in = 0; wb_data_in = 0;
      lu_valid = 0; lu_rd = 0; lu_data = 0;
      test_reset();
      test_wb_pass();
      test_lu_path();
      test_starve();
      test_back_to_back();
      test_x0();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
